// File: rtl/fetch_front_end_pkg.sv
// Shared types and constants for the fetch front end.
// No logic; compile-time only.
// Not applicable (no handshakes here).
package fe_pkg;

    // Front-end state encoding, kept as plain logic constants for legacy tools.
    typedef logic [1:0] fe_state_t;
    localparam fe_state_t FE_RUN   = 2'd0;
    localparam fe_state_t FE_STALL = 2'd1;
    localparam fe_state_t FE_FLUSH = 2'd2;

    // Sequential fetch step in bytes.
    localparam int PC_INCR = 4;

    // Default bubble instruction word.
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // Width of the stall/flush statistics counters.
    localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/fetch_front_end_if.sv
// Hazard-control, imem, decode and debug signals of the fetch front end.
// Wires only; no latency.
// Stall signals from hazard detection are the only flow control.
interface fetch_front_end_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int CTRL_WIDTH  = 9
);
    import fe_pkg::*;

    // Hazard detection and branch resolution
    logic                   PCload;
    logic                   IF_ID_Write;
    logic                   ControlLoad;
    logic                   BRAL;
    logic [PC_WIDTH-1:0]    br_target;
    // Instruction memory and main decoder
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic [CTRL_WIDTH-1:0]  id_ctrl;
    // Pipeline register outputs
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] IF_ID_Instr;
    logic [PC_WIDTH-1:0]    IF_ID_PC4;
    logic                   IF_ID_Valid;
    logic [CTRL_WIDTH-1:0]  ID_EX_Ctrl;
    // Debug and statistics
    fe_state_t              fe_state;
    logic [CNT_WIDTH-1:0]   stall_cnt;
    logic [CNT_WIDTH-1:0]   flush_cnt;

    // Surrounding pipeline side
    modport master (
        output PCload, IF_ID_Write, ControlLoad, BRAL, br_target, imem_instr, id_ctrl,
        input  pc, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, ID_EX_Ctrl, fe_state,
               stall_cnt, flush_cnt
    );

    // Fetch front end side
    modport slave (
        input  PCload, IF_ID_Write, ControlLoad, BRAL, br_target, imem_instr, id_ctrl,
        output pc, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, ID_EX_Ctrl, fe_state,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fetch_front_end_sat_counter.sv
// Saturating event counter.
// One cycle from inc to updated count.
// No backpressure; sticks at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // Count up on inc, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_front_end.sv
// PC, IF/ID register and ID/EX control register under hazard-unit stall/redirect control.
// One cycle from inputs to all registered outputs.
// PCload/IF_ID_Write hold state; a taken branch in ID overrides any stall.
module fetch_front_end
    import fe_pkg::*;
#(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     CTRL_WIDTH  = 9,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(DEFAULT_NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst,
    fetch_front_end_if.slave bus
);

    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    pc_plus4;
    logic [INSTR_WIDTH-1:0] if_id_instr_q;
    logic [PC_WIDTH-1:0]    if_id_pc4_q;
    logic                   if_id_valid_q;
    logic [CTRL_WIDTH-1:0]  id_ex_ctrl_q;
    fe_state_t              state_q;
    logic                   br;
    logic                   stall;
    logic [CNT_WIDTH-1:0]   stall_cnt;
    logic [CNT_WIDTH-1:0]   flush_cnt;

    // A bubble in IF/ID can never redirect, even if BRAL is still asserted.
    assign br       = bus.BRAL & if_id_valid_q;
    assign stall    = ~bus.PCload | ~bus.IF_ID_Write;
    assign pc_plus4 = pc_q + PC_WIDTH'(PC_INCR);

    // PC: redirect beats hold; otherwise advance whenever PCload permits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (br) begin
            pc_q <= bus.br_target;
        end else if (bus.PCload) begin
            pc_q <= pc_plus4;
        end
    end

    // IF/ID: squash on redirect (PC4 kept), load when writable, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
        end else if (br) begin
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else if (bus.IF_ID_Write) begin
            if_id_instr_q <= bus.imem_instr;
            if_id_pc4_q   <= pc_plus4;
            if_id_valid_q <= 1'b1;
        end
    end

    // ID/EX control: pass decode of a real instruction, zero for a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_ctrl_q <= '0;
        end else begin
            id_ex_ctrl_q <= (bus.ControlLoad & if_id_valid_q) ? bus.id_ctrl : '0;
        end
    end

    // Debug state follows the per-cycle priority directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FE_RUN;
        end else if (br) begin
            state_q <= FE_FLUSH;
        end else if (stall) begin
            state_q <= FE_STALL;
        end else begin
            state_q <= FE_RUN;
        end
    end

    // A cycle with both redirect and stall counts only as a flush.
    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall & ~br),
        .cnt (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br),
        .cnt (flush_cnt)
    );

    assign bus.pc          = pc_q;
    assign bus.IF_ID_Instr = if_id_instr_q;
    assign bus.IF_ID_PC4   = if_id_pc4_q;
    assign bus.IF_ID_Valid = if_id_valid_q;
    assign bus.ID_EX_Ctrl  = id_ex_ctrl_q;
    assign bus.fe_state    = state_q;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_fetch_front_end.sv
// Directed self-checking bench for fetch_front_end.
// Samples 1 time unit after each rising edge; drives inputs right after sampling.
// Stall/redirect scenarios each have their own task with hand-computed values.
module tb_fetch_front_end;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_front_end_if #(.PC_WIDTH(32), .INSTR_WIDTH(32), .CTRL_WIDTH(9)) bus ();

    fetch_front_end #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .CTRL_WIDTH(9),
        .RESET_PC(32'h0), .NOP_INSTR(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic pcl, input logic ifw, input logic cl);
        bus.PCload      = pcl;
        bus.IF_ID_Write = ifw;
        bus.ControlLoad = cl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_ctrl(1'b1, 1'b1, 1'b1);
        bus.BRAL = 1'b0; bus.br_target = 32'h0;
        bus.imem_instr = 32'h8C01_0004; bus.id_ctrl = 9'h055;
        rst = 1'b1;
        step(); step();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", bus.pc); end
        checks++; if (bus.IF_ID_Instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", bus.IF_ID_Instr); end
        checks++; if (bus.IF_ID_PC4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 00000000", bus.IF_ID_PC4); end
        checks++; if (bus.IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.IF_ID_Valid); end
        checks++; if (bus.ID_EX_Ctrl !== 9'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 000", bus.ID_EX_Ctrl); end
        checks++; if (bus.fe_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.fe_state); end
        checks++; if (bus.stall_cnt !== 16'h0 || bus.flush_cnt !== 16'h0)
            begin errors++; $display("FAIL reset_cnts: got %h/%h want 0000/0000", bus.stall_cnt, bus.flush_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_run();
        logic [31:0] exp_pc;
        logic [8:0]  exp_ctrl;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_pc   = 32'(4 * i);
            exp_ctrl = (i == 1) ? 9'h000 : 9'h055;
            checks++; if (bus.pc !== exp_pc) begin errors++; $display("FAIL run_pc[%0d]: got %h want %h", i, bus.pc, exp_pc); end
            checks++; if (bus.IF_ID_PC4 !== exp_pc || bus.IF_ID_Valid !== 1'b1 || bus.IF_ID_Instr !== 32'h8C01_0004)
                begin errors++; $display("FAIL run_ifid[%0d]: got %h/%b/%h want %h/1/8c010004", i, bus.IF_ID_PC4, bus.IF_ID_Valid, bus.IF_ID_Instr, exp_pc); end
            checks++; if (bus.ID_EX_Ctrl !== exp_ctrl) begin errors++; $display("FAIL run_ctrl[%0d]: got %h want %h", i, bus.ID_EX_Ctrl, exp_ctrl); end
            checks++; if (bus.fe_state !== 2'd0 || bus.stall_cnt !== 16'h0 || bus.flush_cnt !== 16'h0)
                begin errors++; $display("FAIL run_state[%0d]: got %0d/%h/%h want 0/0000/0000", i, bus.fe_state, bus.stall_cnt, bus.flush_cnt); end
        end
    endtask

    // Load-use stall at pc=8, then redirect with simultaneous stall, then BRAL on a bubble.
    task automatic test_stall_redirect();
        do_reset();
        set_ctrl(1'b1, 1'b1, 1'b1);
        bus.BRAL = 1'b0; bus.imem_instr = 32'h8C01_0004;
        step(); step();
        set_ctrl(1'b0, 1'b0, 1'b0);
        bus.imem_instr = 32'hDEAD_BEEF; bus.id_ctrl = 9'h0FF;
        step();
        checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL stall_pc: got %h want 00000008", bus.pc); end
        checks++; if (bus.IF_ID_Instr !== 32'h8C01_0004 || bus.IF_ID_PC4 !== 32'h8 || bus.IF_ID_Valid !== 1'b1)
            begin errors++; $display("FAIL stall_ifid: got %h/%h/%b want 8c010004/00000008/1", bus.IF_ID_Instr, bus.IF_ID_PC4, bus.IF_ID_Valid); end
        checks++; if (bus.ID_EX_Ctrl !== 9'h0) begin errors++; $display("FAIL stall_ctrl: got %h want 000", bus.ID_EX_Ctrl); end
        checks++; if (bus.fe_state !== 2'd1 || bus.stall_cnt !== 16'd1)
            begin errors++; $display("FAIL stall_state: got %0d/%h want 1/0001", bus.fe_state, bus.stall_cnt); end
        set_ctrl(1'b1, 1'b1, 1'b1);
        step();
        checks++; if (bus.pc !== 32'hC || bus.IF_ID_Instr !== 32'hDEAD_BEEF || bus.IF_ID_PC4 !== 32'hC)
            begin errors++; $display("FAIL resume: got %h/%h/%h want 0000000c/deadbeef/0000000c", bus.pc, bus.IF_ID_Instr, bus.IF_ID_PC4); end
        checks++; if (bus.ID_EX_Ctrl !== 9'h0FF || bus.fe_state !== 2'd0)
            begin errors++; $display("FAIL resume_ctrl: got %h/%0d want 0ff/0", bus.ID_EX_Ctrl, bus.fe_state); end
        // Redirect while PCload=0: branch wins, counted only as a flush.
        set_ctrl(1'b0, 1'b1, 1'b1);
        bus.BRAL = 1'b1; bus.br_target = 32'h40; bus.id_ctrl = 9'h1A5;
        step();
        checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL br_pc: got %h want 00000040", bus.pc); end
        checks++; if (bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_Instr !== 32'h0 || bus.IF_ID_PC4 !== 32'hC)
            begin errors++; $display("FAIL br_ifid: got %b/%h/%h want 0/00000000/0000000c", bus.IF_ID_Valid, bus.IF_ID_Instr, bus.IF_ID_PC4); end
        checks++; if (bus.ID_EX_Ctrl !== 9'h1A5) begin errors++; $display("FAIL br_ctrl: got %h want 1a5", bus.ID_EX_Ctrl); end
        checks++; if (bus.fe_state !== 2'd2 || bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd1)
            begin errors++; $display("FAIL br_cnts: got %0d/%h/%h want 2/0001/0001", bus.fe_state, bus.flush_cnt, bus.stall_cnt); end
        // BRAL still high against a bubble: ignored.
        set_ctrl(1'b1, 1'b1, 1'b1);
        step();
        checks++; if (bus.pc !== 32'h44 || bus.ID_EX_Ctrl !== 9'h0)
            begin errors++; $display("FAIL bubble_br: got %h/%h want 00000044/000", bus.pc, bus.ID_EX_Ctrl); end
        checks++; if (bus.flush_cnt !== 16'd1 || bus.fe_state !== 2'd0 || bus.IF_ID_Valid !== 1'b1 || bus.IF_ID_PC4 !== 32'h44)
            begin errors++; $display("FAIL bubble_state: got %h/%0d/%b/%h want 0001/0/1/00000044", bus.flush_cnt, bus.fe_state, bus.IF_ID_Valid, bus.IF_ID_PC4); end
    endtask

    // Redirect to the top of the address space and advance past it.
    task automatic test_wrap();
        bus.BRAL = 1'b1; bus.br_target = 32'hFFFF_FFFC;
        step();
        checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.flush_cnt !== 16'd2)
            begin errors++; $display("FAIL wrap_br: got %h/%h want fffffffc/0002", bus.pc, bus.flush_cnt); end
        bus.BRAL = 1'b0;
        step();
        checks++; if (bus.pc !== 32'h0 || bus.IF_ID_PC4 !== 32'h0 || bus.IF_ID_Valid !== 1'b1)
            begin errors++; $display("FAIL wrap_pc: got %h/%h/%b want 00000000/00000000/1", bus.pc, bus.IF_ID_PC4, bus.IF_ID_Valid); end
    endtask

    // Only one of PCload / IF_ID_Write low at a time.
    task automatic test_partial_stall();
        set_ctrl(1'b1, 1'b0, 1'b1);
        step();
        checks++; if (bus.pc !== 32'h4 || bus.IF_ID_PC4 !== 32'h0 || bus.fe_state !== 2'd1 || bus.stall_cnt !== 16'd2)
            begin errors++; $display("FAIL ifw_stall: got %h/%h/%0d/%h want 00000004/00000000/1/0002", bus.pc, bus.IF_ID_PC4, bus.fe_state, bus.stall_cnt); end
        set_ctrl(1'b0, 1'b1, 1'b1);
        bus.imem_instr = 32'h1234_5678;
        step();
        checks++; if (bus.pc !== 32'h4 || bus.IF_ID_Instr !== 32'h1234_5678 || bus.IF_ID_PC4 !== 32'h8 || bus.stall_cnt !== 16'd3)
            begin errors++; $display("FAIL pcl_stall: got %h/%h/%h/%h want 00000004/12345678/00000008/0003", bus.pc, bus.IF_ID_Instr, bus.IF_ID_PC4, bus.stall_cnt); end
        set_ctrl(1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_saturation();
        do_reset();
        set_ctrl(1'b0, 1'b0, 1'b0);
        repeat (65534) step();
        checks++; if (bus.stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", bus.stall_cnt); end
        step();
        checks++; if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h want ffff", bus.stall_cnt); end
        repeat (5) step();
        checks++; if (bus.stall_cnt !== 16'hFFFF || bus.pc !== 32'h0)
            begin errors++; $display("FAIL sat_hold: got %h/%h want ffff/00000000", bus.stall_cnt, bus.pc); end
        set_ctrl(1'b1, 1'b1, 1'b1);
    endtask

    // Reset asserted between edges during a stall must clear outputs at once.
    task automatic test_async_reset();
        do_reset();
        set_ctrl(1'b1, 1'b1, 1'b1);
        bus.imem_instr = 32'h8C01_0004; bus.id_ctrl = 9'h1FF;
        step();
        set_ctrl(1'b0, 1'b0, 1'b1);
        step(); step();
        checks++; if (bus.pc !== 32'h4 || bus.stall_cnt !== 16'd2 || bus.ID_EX_Ctrl !== 9'h1FF)
            begin errors++; $display("FAIL pre_arst: got %h/%h/%h want 00000004/0002/1ff", bus.pc, bus.stall_cnt, bus.ID_EX_Ctrl); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.pc !== 32'h0 || bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_Instr !== 32'h0 || bus.IF_ID_PC4 !== 32'h0)
            begin errors++; $display("FAIL arst_ifid: got %h/%b/%h/%h want 00000000/0/00000000/00000000", bus.pc, bus.IF_ID_Valid, bus.IF_ID_Instr, bus.IF_ID_PC4); end
        checks++; if (bus.ID_EX_Ctrl !== 9'h0 || bus.fe_state !== 2'd0 || bus.stall_cnt !== 16'h0 || bus.flush_cnt !== 16'h0)
            begin errors++; $display("FAIL arst_misc: got %h/%0d/%h/%h want 000/0/0000/0000", bus.ID_EX_Ctrl, bus.fe_state, bus.stall_cnt, bus.flush_cnt); end
        #1 rst = 1'b0;
        set_ctrl(1'b1, 1'b1, 1'b1);
        step();
        checks++; if (bus.pc !== 32'h4 || bus.IF_ID_PC4 !== 32'h4 || bus.IF_ID_Valid !== 1'b1)
            begin errors++; $display("FAIL post_arst: got %h/%h/%b want 00000004/00000004/1", bus.pc, bus.IF_ID_PC4, bus.IF_ID_Valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run();
        test_stall_redirect();
        test_wrap();
        test_partial_stall();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_front_end.md
Name: fetch_front_end

Overview:
- Consumer end of the hazard-control interface: owns the PC register, the IF/ID pipeline register and the control-field half of the ID/EX register.
- Applies the PCload / IF_ID_Write / ControlLoad stall signals and the BRAL redirect generated by hazard detection.
- Sits between instruction memory and the ID stage.
- Provides stall/flush statistics and a visible front-end state for debug.

Parameters:
- PC_WIDTH, 32, width of PC and branch target
- INSTR_WIDTH, 32, instruction width
- CTRL_WIDTH, 9, width of decoded control bundle passed to ID/EX
- RESET_PC, 0, PC value after reset
- NOP_INSTR, 0, instruction word inserted as a bubble

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- PCload  in  1  1 = PC may advance; 0 = hold PC
- IF_ID_Write  in  1  1 = IF/ID may load; 0 = hold IF/ID
- ControlLoad  in  1  1 = pass id_ctrl into ID/EX; 0 = insert zero control (bubble)
- BRAL  in  1  branch/jump taken, resolved in ID
- br_target  in  PC_WIDTH  redirect address, valid with BRAL
- imem_instr  in  INSTR_WIDTH  instruction at pc (combinational imem read)
- id_ctrl  in  CTRL_WIDTH  control bundle from main decoder for the IF/ID instruction
- pc  out  PC_WIDTH  current fetch address
- IF_ID_Instr  out  INSTR_WIDTH  instruction presented to ID
- IF_ID_PC4  out  PC_WIDTH  PC+4 of that instruction
- IF_ID_Valid  out  1  IF/ID holds a real instruction
- ID_EX_Ctrl  out  CTRL_WIDTH  registered control bundle for EX
- fe_state  out  2  0=RUN, 1=STALL, 2=FLUSH
- stall_cnt  out  16  saturating count of stall cycles
- flush_cnt  out  16  saturating count of redirects

Behaviour:
- Reset values (async, asserted immediately, even mid-stall or mid-flush):
  - pc=RESET_PC
  - IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_Valid=0
  - ID_EX_Ctrl=0
  - counters=0
  - fe_state=RUN
- All updates occur on the rising clk edge; outputs are registered; one-cycle latency from inputs to outputs.
- br = BRAL & IF_ID_Valid. BRAL with IF_ID_Valid=0 is ignored entirely, so a bubble never redirects.
- Priority 1, br=1:
  - pc<=br_target; overrides PCload=0.
  - IF/ID<=NOP_INSTR, PC4 unchanged, Valid<=0.
  - fe_state<=FLUSH; flush_cnt+=1.
- Priority 2, PCload=0 or IF_ID_Write=0:
  - pc holds if PCload=0, else pc<=pc+4.
  - IF/ID holds all fields if IF_ID_Write=0, else loads normally.
  - fe_state<=STALL; stall_cnt+=1.
- Priority 3, otherwise:
  - pc<=pc+4.
  - IF_ID_Instr<=imem_instr, IF_ID_PC4<=pc+4, Valid<=1.
  - fe_state<=RUN.
- ID_EX_Ctrl, every cycle independent of priority: <= (ControlLoad & IF_ID_Valid) ? id_ctrl : 0. A taken branch with ControlLoad=1 still passes its own control to EX.
- FSM transitions are fully determined by the priority above each cycle; any state may go to any state. No multi-cycle sequences are hidden in the FSM.
- Arithmetic: pc+4 wraps modulo 2^PC_WIDTH (max PC + 4 -> 0 + 3 low bits pattern). br_target is used verbatim; no alignment check.
- Counters saturate at 16'hFFFF and do not wrap.
- Simultaneous br and stall: br wins. That cycle counts as a flush only, not a stall.
- Consecutive stalls: pc and IF/ID remain stable for every stalled cycle; stall_cnt increments each cycle.

Decomposition:
- Package fe_pkg:
  - fe_state_t encoding (RUN/STALL/FLUSH)
  - PC_INCR=4
  - default NOP_INSTR
  - counter width 16
- One sub-module, sat_counter (width param, inc input, async reset), instantiated for stall_cnt and flush_cnt.
- PC, IF/ID and ID/EX-control registers remain in the top module.

Test Plan:
- Reset then 4 cycles of all-1 controls, imem_instr=0x8C010004 -> pc 0,4,8,C,10; IF_ID_Valid=1 from cycle 1; IF_ID_PC4=pc_prev+4; fe_state=RUN; counters 0.
- Load-use: PCload=IF_ID_Write=ControlLoad=0 for 1 cycle at pc=0x8 -> pc stays 0x8, IF/ID unchanged, ID_EX_Ctrl=0, fe_state=STALL, stall_cnt=1; resumes at 0xC next cycle.
- Redirect: IF_ID_Valid=1, BRAL=1, br_target=0x40, PCload=0, ControlLoad=1, id_ctrl=0x1A5 -> pc=0x40, IF_ID_Valid=0, IF_ID_Instr=NOP, ID_EX_Ctrl=0x1A5, fe_state=FLUSH, flush_cnt=1, stall_cnt unchanged.
- BRAL held high the following cycle (IF_ID_Valid=0) -> ignored: pc=0x44, ID_EX_Ctrl=0, flush_cnt stays 1.
- Wrap and saturation:
  - pc at 0xFFFFFFFC, advance -> pc=0x0.
  - 65540 stall cycles -> stall_cnt=0xFFFF and holds.
- Assert rst mid-stall between clock edges -> all outputs take reset values immediately, before the next clk edge; first fetch after release is from RESET_PC.
